// File: rtl/bpm_digit_scan.sv
// Heart-rate display back-end: serial double-dabble BCD conversion,
// multiplexed 7-segment drive with anti-ghost blanking and "---" pattern.
module bpm_digit_scan #(
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bpm,
  input  logic       bpm_valid,
  input  logic       no_signal,
  input  logic [1:0] selec_mux,
  output logic       busy,
  output logic [2:0] an,
  output logic [6:0] seg
);

  localparam logic [7:0] BLK = 8'(BLANK_CYCLES);

  logic        busy_q, busy_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shr_q, shr_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  hun_q, hun_d;
  logic [3:0]  ten_q, ten_d;
  logic [3:0]  uni_q, uni_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  blk_q, blk_d;
  logic        ns_q, ns_d;
  logic        run_q, run_d;

  logic [11:0] bcd_adj;
  logic [19:0] shifted;

  function automatic logic [3:0] adj3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    shr_d   = shr_q;
    bcd_d   = bcd_q;
    hun_d   = hun_q;
    ten_d   = ten_q;
    uni_d   = uni_q;
    bcd_adj = {adj3(bcd_q[11:8]), adj3(bcd_q[7:4]), adj3(bcd_q[3:0])};
    shifted = {bcd_adj, shr_q} << 1;
    if (busy_q) begin
      cnt_d = cnt_q + 3'd1;
      bcd_d = shifted[19:8];
      shr_d = shifted[7:0];
      // Digits commit together only on the final iteration
      if (cnt_q == 3'd7) begin
        busy_d = 1'b0;
        hun_d  = shifted[19:16];
        ten_d  = shifted[15:12];
        uni_d  = shifted[11:8];
      end
    end else if (bpm_valid) begin
      busy_d = 1'b1;
      cnt_d  = 3'd0;
      shr_d  = bpm;
      bcd_d  = 12'd0;
    end
  end

  always_comb begin
    sel_d = selec_mux;
    blk_d = blk_q;
    if (selec_mux != sel_q) blk_d = BLK;
    else if (blk_q != 8'd0) blk_d = blk_q - 8'd1;
    ns_d  = no_signal;
    run_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      cnt_q  <= 3'd0;
      shr_q  <= 8'd0;
      bcd_q  <= 12'd0;
      hun_q  <= 4'd0;
      ten_q  <= 4'd0;
      uni_q  <= 4'd0;
      sel_q  <= 2'd0;
      blk_q  <= 8'd0;
      ns_q   <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      shr_q  <= shr_d;
      bcd_q  <= bcd_d;
      hun_q  <= hun_d;
      ten_q  <= ten_d;
      uni_q  <= uni_d;
      sel_q  <= sel_d;
      blk_q  <= blk_d;
      ns_q   <= ns_d;
      run_q  <= run_d;
    end
  end

  logic       off;
  logic       sup;
  logic [3:0] dig;
  logic [6:0] code;

  always_comb begin
    // run_q keeps anodes dark while reset is held
    off = !run_q || (blk_q != 8'd0) || (sel_q == 2'd3);
    an  = 3'b111;
    dig = uni_q;
    sup = 1'b0;
    unique case (1'b1)
      (sel_q == 2'd0): begin
        an  = 3'b110;
        dig = uni_q;
      end
      (sel_q == 2'd1): begin
        an  = 3'b101;
        dig = ten_q;
        sup = (hun_q == 4'd0) && (ten_q == 4'd0);
      end
      (sel_q == 2'd2): begin
        an  = 3'b011;
        dig = hun_q;
        sup = (hun_q == 4'd0);
      end
      default: an = 3'b111;
    endcase
    if (off) an = 3'b111;
  end

  always_comb begin
    case (dig)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = 7'b1111111;
    endcase
    if (off)       seg = 7'b1111111;
    else if (ns_q) seg = 7'b0111111;
    else if (sup)  seg = 7'b1111111;
    else           seg = code;
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_bpm_digit_scan.sv
// Randomised and directed bench for bpm_digit_scan against a
// value-level model of the readout.
module tb_bpm_digit_scan;

  localparam int BLANK = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bpm = '0;
  logic       bpm_valid = 1'b0;
  logic       no_signal = 1'b0;
  logic [1:0] selec_mux = '0;
  logic       busy;
  logic [2:0] an;
  logic [6:0] seg;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  bpm_digit_scan #(.BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst), .bpm(bpm), .bpm_valid(bpm_valid),
    .no_signal(no_signal), .selec_mux(selec_mux),
    .busy(busy), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  logic [6:0] segtab [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Model: value shown, pending value, cycles left, select age
  int m_left = 0;
  int m_pend = 0;
  int m_disp = 0;
  int m_sel = 0;
  int m_since = BLANK;
  bit m_ns = 1'b0;
  bit m_live = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left = 0; m_pend = 0; m_disp = 0; m_sel = 0;
      m_since = BLANK; m_ns = 1'b0; m_live = 1'b0;
    end else begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_disp = m_pend;
      end else if (bpm_valid) begin
        m_pend = int'(bpm);
        m_left = 8;
      end
      if (int'(selec_mux) != m_sel) m_since = 0;
      else if (m_since < 1000) m_since++;
      m_sel = int'(selec_mux);
      m_ns = no_signal;
      m_live = 1'b1;
    end
  end

  function automatic bit m_off();
    return !m_live || m_sel == 3 || m_since < BLANK;
  endfunction

  function automatic logic [2:0] exp_an();
    logic [2:0] a;
    a = 3'b111;
    if (!m_off()) a[m_sel] = 1'b0;
    return a;
  endfunction

  function automatic logic [6:0] exp_seg();
    int d;
    if (m_off()) return 7'b1111111;
    if (m_ns) return 7'b0111111;
    if (m_sel == 2) begin
      if (m_disp < 100) return 7'b1111111;
      d = m_disp / 100;
    end else if (m_sel == 1) begin
      if (m_disp < 10) return 7'b1111111;
      d = (m_disp / 10) % 10;
    end else begin
      d = m_disp % 10;
    end
    return segtab[d];
  endfunction

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_busy", 32'(busy), 32'(m_left > 0));
      check("m_an", 32'(an), 32'(exp_an()));
      check("m_seg", 32'(seg), 32'(exp_seg()));
    end
  end

  task automatic show(input logic [1:0] s, input logic [2:0] ea,
                      input logic [6:0] es, input string nm);
    selec_mux = s;
    repeat (6) @(negedge clk);
    check({nm, "_an"}, 32'(an), 32'(ea));
    check({nm, "_seg"}, 32'(seg), 32'(es));
  endtask

  task automatic convert(input logic [7:0] v, output int nb);
    bpm = v;
    bpm_valid = 1'b1;
    @(negedge clk);
    bpm_valid = 1'b0;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) nb++;
      @(negedge clk);
    end
  endtask

  task automatic dwell(input logic [1:0] s, input string nm);
    int off;
    selec_mux = s;
    off = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i < 10 && an == 3'b111) off++;
    end
    check({nm, "_offcycles"}, 32'(off), 32'(BLANK));
  endtask

  initial begin
    int nb;
    #1 rst = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_an", 32'(an), 32'(3'b111));
    check("rst_seg", 32'(seg), 32'(7'b1111111));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rel_an", 32'(an), 32'(3'b110));
    check("rel_seg", 32'(seg), 32'(7'b1000000));

    convert(8'd72, nb);
    check("busy72", 32'(nb), 32'd8);
    show(2'd0, 3'b110, 7'b0100100, "u72");
    show(2'd1, 3'b101, 7'b1111000, "t72");
    show(2'd2, 3'b011, 7'b1111111, "h72");

    bpm = 8'd255;
    bpm_valid = 1'b1;
    @(negedge clk);
    bpm_valid = 1'b0;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin
        bpm = 8'd5;
        bpm_valid = 1'b1;
      end else begin
        bpm_valid = 1'b0;
      end
      if (busy) nb++;
      @(negedge clk);
    end
    check("busy255", 32'(nb), 32'd8);
    show(2'd2, 3'b011, 7'b0100100, "h255");
    show(2'd1, 3'b101, 7'b0010010, "t255");
    show(2'd0, 3'b110, 7'b0010010, "u255");

    convert(8'd7, nb);
    check("u7", 32'(seg), 32'(7'b1111000));
    show(2'd1, 3'b101, 7'b1111111, "t7");
    show(2'd2, 3'b011, 7'b1111111, "h7");
    convert(8'd100, nb);
    check("h100", 32'(seg), 32'(7'b1111001));
    show(2'd1, 3'b101, 7'b1000000, "t100");
    show(2'd0, 3'b110, 7'b1000000, "u100");

    dwell(2'd1, "d1");
    dwell(2'd2, "d2");
    dwell(2'd0, "d0");
    show(2'd3, 3'b111, 7'b1111111, "sel3");
    selec_mux = 2'd0;

    convert(8'd120, nb);
    no_signal = 1'b1;
    @(negedge clk);
    check("ns_u", 32'(seg), 32'(7'b0111111));
    show(2'd1, 3'b101, 7'b0111111, "ns_t");
    show(2'd2, 3'b011, 7'b0111111, "ns_h");
    no_signal = 1'b0;
    @(negedge clk);
    check("ns_off_h", 32'(seg), 32'(7'b1111001));
    show(2'd1, 3'b101, 7'b0100100, "ns_off_t");
    show(2'd0, 3'b110, 7'b1000000, "ns_off_u");

    for (int c = 0; c < 4000; c++) begin
      bpm = 8'($urandom);
      bpm_valid = ($urandom % 6) == 0;
      if ($urandom % 50 == 0) no_signal = ~no_signal;
      if ($urandom % 40 == 0) selec_mux = 2'($urandom);
      if (c == 2000) begin
        #3 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    bpm_valid = 1'b0;
    no_signal = 1'b0;

    bpm = 8'd200;
    bpm_valid = 1'b1;
    @(negedge clk);
    bpm_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_an", 32'(an), 32'(3'b111));
    check("mid_seg", 32'(seg), 32'(7'b1111111));
    selec_mux = 2'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rel_an", 32'(an), 32'(3'b110));
    check("mid_rel_seg", 32'(seg), 32'(7'b1000000));

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bpm_digit_scan.md
Name: bpm_digit_scan

Overview:
- Display back-end for the heart-rate readout. Sits downstream of the 3-way digit selector.
- Accepts an 8-bit BPM value on a strobe and converts it to three BCD digits with a sequential double-dabble (no combinational divider).
- Consumes the 2-bit digit select to drive one-hot active-low anodes and active-low 7-segment cathodes.
- Adds anti-ghosting blanking on every select change, leading-zero suppression and a "no signal" dash pattern.

Parameters:
- BLANK_CYCLES, 4: cycles all anodes are held off after each change of selec_mux. Range 0..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- bpm  in  8  binary heart rate, 0..255
- bpm_valid  in  1  one-cycle strobe; bpm is valid this cycle
- no_signal  in  1  level; high = no pulse detected, show "---"
- selec_mux  in  2  digit select: 0 = units, 1 = tens, 2 = hundreds, 3 = invalid
- busy  out  1  conversion in progress
- an  out  3  anode enables, active-low; an[0] = units, an[2] = hundreds
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (rst low, asynchronous):
  - busy = 0, an = 3'b111, seg = 7'b1111111.
  - Digit registers = 0, sel_q = 0, blank counter = 0, ns_q = 0, converter idle.
  - Releasing reset shows "0" on units when units is selected.
- Conversion accept:
  - On an edge where bpm_valid = 1 and busy = 0, latch bpm into the shift register, clear the BCD scratch and set busy.
  - A bpm_valid that arrives while busy = 1 is dropped. There is no queueing.
- Conversion run:
  - busy stays high for exactly 8 cycles. Each cycle is one double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left 1.
  - On the edge ending the 8th busy cycle, hundreds/tens/units update atomically and busy falls.
  - Displayed digits never show partial results.
  - A new accept is possible on the first cycle after busy falls.
- Reset mid-conversion aborts the conversion and clears all state.
- Select tracking:
  - Register sel_q <= selec_mux every cycle.
  - When selec_mux != sel_q at an edge, load the blank counter with BLANK_CYCLES. Otherwise, if the counter is nonzero, decrement it.
- Anode output (from registered state only, so no input-to-output combinational path):
  - an = 3'b111 if the blank counter != 0 or sel_q == 3.
  - Otherwise an is active-low one-hot on sel_q.
  - Net effect: after a select change at edge E, anodes stay off for BLANK_CYCLES cycles, and the new digit drives on the following cycle.
  - With BLANK_CYCLES = 0, the new digit appears 1 cycle after the change.
- Segment output:
  - seg shows the digit for sel_q.
  - seg = 7'b1111111 whenever an = 3'b111.
- Segment codes:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - dash = 0111111, blank = 1111111
- Leading-zero suppression:
  - Hundreds is blank (anode still asserted, seg = 1111111) if hundreds == 0.
  - Tens is blank if hundreds == 0 and tens == 0.
  - Units is always shown.
- no_signal:
  - Registered into ns_q.
  - While ns_q = 1, every selected digit shows dash, overriding digit values and suppression.
  - Conversions continue underneath.
- Simultaneous bpm_valid and no_signal rise: both take effect independently.
  - Dashes appear 1 cycle later.
  - The value appears once ns_q falls.

Test Plan:
- Reset with rst low mid-run, BLANK_CYCLES = 4 -> an = 111, seg = 1111111, busy = 0 while rst low. After release with selec_mux = 0: an = 110, seg = 1000000.
- bpm = 8'd72 strobe -> busy high for exactly 8 cycles. Then units = 2 (0100100), tens = 7 (1111000), hundreds blank (1111111 with an = 011).
- bpm = 255, then bpm = 5 strobed 3 cycles later -> second strobe dropped. Display shows 2/5/5 and busy falls 8 cycles after the first accept.
- bpm = 7 -> hundreds and tens blank, units = 1111000. Then bpm = 100 -> hundreds = 1111001, tens = 1000000, units = 1000000.
- selec_mux steps 0 -> 1 -> 2 -> 0 with the digit dwelling 100 cycles each, BLANK_CYCLES = 4 -> an = 111 for exactly 4 cycles after each change, then the correct one-hot. selec_mux = 3 -> an = 111 held.
- no_signal high with the value at 120 -> 1 cycle later every digit shows 0111111. no_signal low -> 1/2/0 restored next cycle.
